// File: rtl/rectangle_stream_decoder.sv
// Decodes a draw_rectangle coordinate stream into its bounding box (s_x, s_y, height, width)
// plus exact-fill and emission-order flags, reported after a WIDTH-cycle shift-add multiply.
module rectangle_stream_decoder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic             _in_valid,
  output logic             _in_ready,
  input  logic [WIDTH-1:0] _in0,
  input  logic [WIDTH-1:0] _in1,
  input  logic             _in_done,
  output logic [WIDTH-1:0] s_x,
  output logic [WIDTH-1:0] s_y,
  output logic [WIDTH-1:0] height,
  output logic [WIDTH-1:0] width,
  output logic             _filled,
  output logic             _ordered,
  output logic             _done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    MULT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] min_x, max_x, min_y, max_y;
  logic [WIDTH-1:0] prev_x, prev_y, row_x0;
  logic [PW-1:0]    count;
  logic             ord;
  logic             seen;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    product;
  logic [CW-1:0]    mcnt;

  logic             xfer;
  logic [WIDTH-1:0] x_span, y_span;
  logic             step_first;
  logic [PW-1:0]    mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [PW-1:0]    prod_next;
  logic             ord_step;

  // Spans wrap in WIDTH bits, so a full-range span reads 0.
  always_comb begin
    xfer       = (state == COLLECT) && _in_valid && _in_ready;
    x_span     = max_x - min_x + WIDTH'(1);
    y_span     = max_y - min_y + WIDTH'(1);
    step_first = (mcnt == CW'(0));
    mul_a      = step_first ? PW'(x_span) : mcand;
    mul_b      = step_first ? y_span : mplier;
    prod_next  = product + (mul_b[0] ? mul_a : PW'(0));
    ord_step   = ((_in0 == prev_x + WIDTH'(1)) && (_in1 == prev_y)) ||
                 ((_in0 == row_x0) && (_in1 == prev_y + WIDTH'(1)));
  end

  // Operand registers are loaded from the spans on the first multiply step because the
  // final transfer may land on the same edge that samples _in_done.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state     <= IDLE;
      min_x     <= '0;
      max_x     <= '0;
      min_y     <= '0;
      max_y     <= '0;
      prev_x    <= '0;
      prev_y    <= '0;
      row_x0    <= '0;
      count     <= '0;
      ord       <= 1'b0;
      seen      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      product   <= '0;
      mcnt      <= '0;
      _in_ready <= 1'b0;
      s_x       <= '0;
      s_y       <= '0;
      height    <= '0;
      width     <= '0;
      _filled   <= 1'b0;
      _ordered  <= 1'b0;
      _done     <= 1'b0;
    end else if (_start) begin
      state     <= COLLECT;
      min_x     <= '0;
      max_x     <= '0;
      min_y     <= '0;
      max_y     <= '0;
      count     <= '0;
      ord       <= 1'b0;
      seen      <= 1'b0;
      _in_ready <= 1'b1;
      _done     <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (xfer) begin
            prev_x <= _in0;
            prev_y <= _in1;
            count  <= count + PW'(1);
            if (!seen) begin
              seen   <= 1'b1;
              min_x  <= _in0;
              max_x  <= _in0;
              min_y  <= _in1;
              max_y  <= _in1;
              row_x0 <= _in0;
              ord    <= 1'b1;
            end else begin
              if (_in0 < min_x) min_x <= _in0;
              if (_in0 > max_x) max_x <= _in0;
              if (_in1 < min_y) min_y <= _in1;
              if (_in1 > max_y) max_y <= _in1;
              ord <= ord & ord_step;
            end
          end
          if (_in_done) begin
            state     <= MULT;
            _in_ready <= 1'b0;
            mcnt      <= '0;
            product   <= '0;
          end
        end
        MULT: begin
          product <= prod_next;
          mcand   <= mul_a << 1;
          mplier  <= mul_b >> 1;
          mcnt    <= mcnt + CW'(1);
          if (mcnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            _done    <= 1'b1;
            s_x      <= seen ? min_x : '0;
            s_y      <= seen ? min_y : '0;
            height   <= seen ? x_span : '0;
            width    <= seen ? y_span : '0;
            _filled  <= seen && (count == prod_next);
            _ordered <= seen && ord;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rectangle_stream_decoder.sv
// Directed bench for rectangle_stream_decoder: a queue-based reference model checked every
// cycle, plus literal expectations for each stimulus case.
module tb_rectangle_stream_decoder;

  localparam int unsigned WIDTH = 32;

  logic             _clock = 1'b0;
  logic             _reset = 1'b0;
  logic             _start = 1'b0;
  logic             _in_valid = 1'b0;
  logic             _in_ready;
  logic [WIDTH-1:0] _in0 = '0;
  logic [WIDTH-1:0] _in1 = '0;
  logic             _in_done = 1'b0;
  logic [WIDTH-1:0] s_x, s_y, height, width;
  logic             _filled, _ordered, _done;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  rectangle_stream_decoder #(.WIDTH(WIDTH)) dut (
    ._clock(_clock), ._reset(_reset), ._start(_start),
    ._in_valid(_in_valid), ._in_ready(_in_ready),
    ._in0(_in0), ._in1(_in1), ._in_done(_in_done),
    .s_x(s_x), .s_y(s_y), .height(height), .width(width),
    ._filled(_filled), ._ordered(_ordered), ._done(_done)
  );

  always #5 _clock = ~_clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted pixels are queued, results derived from the whole stream.
  logic [WIDTH-1:0] qx[$];
  logic [WIDTH-1:0] qy[$];
  int               m_phase = 0;  // 0 idle, 1 collecting, 2 multiplying, 3 done
  int               m_cnt = 0;
  logic [WIDTH-1:0] e_sx = '0, e_sy = '0, e_h = '0, e_w = '0;
  logic             e_f = 1'b0, e_o = 1'b0, e_done = 1'b0, e_ready = 1'b0;

  function automatic void summarize();
    logic [WIDTH-1:0] lo_x, hi_x, lo_y, hi_y, sx, sy;
    logic [63:0]      area;
    bit               ok;
    if (qx.size() == 0) begin
      e_sx = '0; e_sy = '0; e_h = '0; e_w = '0; e_f = 1'b0; e_o = 1'b0;
      return;
    end
    lo_x = qx[0]; hi_x = qx[0]; lo_y = qy[0]; hi_y = qy[0]; ok = 1'b1;
    for (int i = 1; i < qx.size(); i++) begin
      if (qx[i] < lo_x) lo_x = qx[i];
      if (qx[i] > hi_x) hi_x = qx[i];
      if (qy[i] < lo_y) lo_y = qy[i];
      if (qy[i] > hi_y) hi_y = qy[i];
      if (!(((qx[i] == qx[i-1] + 32'd1) && (qy[i] == qy[i-1])) ||
            ((qx[i] == qx[0]) && (qy[i] == qy[i-1] + 32'd1))))
        ok = 1'b0;
    end
    sx = hi_x - lo_x + 32'd1;
    sy = hi_y - lo_y + 32'd1;
    area = 64'(sx) * 64'(sy);
    e_sx = lo_x; e_sy = lo_y; e_h = sx; e_w = sy;
    e_f = (64'(qx.size()) == area);
    e_o = ok;
  endfunction

  always @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      m_phase = 0; qx.delete(); qy.delete();
      e_sx = '0; e_sy = '0; e_h = '0; e_w = '0;
      e_f = 1'b0; e_o = 1'b0; e_done = 1'b0; e_ready = 1'b0;
    end else if (_start) begin
      qx.delete(); qy.delete();
      m_phase = 1; e_ready = 1'b1; e_done = 1'b0;
    end else if (m_phase == 1) begin
      if (_in_valid) begin qx.push_back(_in0); qy.push_back(_in1); end
      if (_in_done) begin m_phase = 2; m_cnt = WIDTH; e_ready = 1'b0; end
    end else if (m_phase == 2) begin
      m_cnt--;
      if (m_cnt == 0) begin summarize(); e_done = 1'b1; m_phase = 3; end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge _clock) begin
    if (checking) begin
      check("in_ready", 64'(_in_ready), 64'(e_ready));
      check("done", 64'(_done), 64'(e_done));
      check("s_x", 64'(s_x), 64'(e_sx));
      check("s_y", 64'(s_y), 64'(e_sy));
      check("height", 64'(height), 64'(e_h));
      check("width", 64'(width), 64'(e_w));
      check("filled", 64'(_filled), 64'(e_f));
      check("ordered", 64'(_ordered), 64'(e_o));
    end
  end

  task automatic do_start();
    _start = 1'b1;
    @(negedge _clock);
    _start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int gap);
    _in_valid = 1'b1; _in0 = x; _in1 = y;
    @(negedge _clock);
    _in_valid = 1'b0;
    repeat (gap) @(negedge _clock);
  endtask

  // Raises _in_done (optionally with a final pixel) and checks _done arrives WIDTH edges later.
  task automatic finish_stream(input bit with_pixel, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y);
    int lat;
    _in_done = 1'b1;
    if (with_pixel) begin _in_valid = 1'b1; _in0 = x; _in1 = y; end
    @(negedge _clock);
    _in_done = 1'b0; _in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      if (lat == 0) begin
        @(negedge _clock);
        if (_done) lat = k;
      end
    end
    check("done_latency", 64'(lat), 64'(WIDTH));
  endtask

  task automatic expect_box(input string tag, input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] ey,
                            input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] ew,
                            input bit ef, input bit eo, input bit check_ord);
    check({tag, ".done"}, 64'(_done), 64'(1));
    check({tag, ".s_x"}, 64'(s_x), 64'(ex));
    check({tag, ".s_y"}, 64'(s_y), 64'(ey));
    check({tag, ".height"}, 64'(height), 64'(eh));
    check({tag, ".width"}, 64'(width), 64'(ew));
    check({tag, ".filled"}, 64'(_filled), 64'(ef));
    if (check_ord) check({tag, ".ordered"}, 64'(_ordered), 64'(eo));
  endtask

  task automatic rect_stream(input int gap);
    send(32'd3, 32'd5, gap); send(32'd4, 32'd5, gap);
    send(32'd3, 32'd6, gap); send(32'd4, 32'd6, gap);
    send(32'd3, 32'd7, gap);
  endtask

  initial begin
    #1 _reset = 1'b1;
    checking = 1'b1;
    repeat (3) @(negedge _clock);
    check("reset.done", 64'(_done), 64'(0));
    check("reset.ready", 64'(_in_ready), 64'(0));
    check("reset.height", 64'(height), 64'(0));
    _reset = 1'b0;
    @(negedge _clock);

    // 1: row-order 2x3 rectangle
    do_start();
    rect_stream(0); send(32'd4, 32'd7, 0);
    finish_stream(1'b0, '0, '0);
    expect_box("case1", 32'd3, 32'd5, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1);

    // 2: missing (4,6)
    do_start();
    send(32'd3, 32'd5, 0); send(32'd4, 32'd5, 0); send(32'd3, 32'd6, 0);
    send(32'd3, 32'd7, 0); send(32'd4, 32'd7, 0);
    finish_stream(1'b0, '0, '0);
    expect_box("case2", 32'd3, 32'd5, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);

    // 3: column order
    do_start();
    send(32'd3, 32'd5, 0); send(32'd3, 32'd6, 0); send(32'd3, 32'd7, 0);
    send(32'd4, 32'd5, 0); send(32'd4, 32'd6, 0); send(32'd4, 32'd7, 0);
    finish_stream(1'b0, '0, '0);
    expect_box("case3", 32'd3, 32'd5, 32'd2, 32'd3, 1'b1, 1'b0, 1'b1);

    // 4: empty stream
    do_start();
    finish_stream(1'b0, '0, '0);
    expect_box("case4", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // 5: gaps, last pixel on the _in_done edge
    do_start();
    send(32'd3, 32'd5, $urandom_range(0, 2)); send(32'd4, 32'd5, $urandom_range(0, 2));
    send(32'd3, 32'd6, $urandom_range(0, 2)); send(32'd4, 32'd6, $urandom_range(0, 2));
    send(32'd3, 32'd7, $urandom_range(0, 2));
    finish_stream(1'b1, 32'd4, 32'd7);
    expect_box("case5", 32'd3, 32'd5, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1);

    // 6: asynchronous reset mid-collect, then full replay
    do_start();
    send(32'd3, 32'd5, 0); send(32'd4, 32'd5, 0); send(32'd3, 32'd6, 0);
    #2 _reset = 1'b1;
    #1;
    check("case6.async_done", 64'(_done), 64'(0));
    check("case6.async_ready", 64'(_in_ready), 64'(0));
    check("case6.async_s_x", 64'(s_x), 64'(0));
    check("case6.async_width", 64'(width), 64'(0));
    @(negedge _clock);
    _reset = 1'b0;
    @(negedge _clock);
    do_start();
    rect_stream(0); send(32'd4, 32'd7, 0);
    finish_stream(1'b0, '0, '0);
    expect_box("case6", 32'd3, 32'd5, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1);

    // 7: full-range x span wraps to 0
    do_start();
    send(32'd0, 32'd0, 0); send(32'hFFFF_FFFF, 32'd0, 0);
    finish_stream(1'b0, '0, '0);
    expect_box("case7", 32'd0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1);

    // results hold across a later _start until the next _done
    do_start();
    repeat (2) @(negedge _clock);
    check("hold.width", 64'(width), 64'(1));
    check("hold.done", 64'(_done), 64'(0));

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
